shift_unit_arbiter: RTL and testbench
=====================================

Name: shift_unit_arbiter

Overview:
- Shares one WIDTH-bit right shift/rotate datapath between two requesters using a round-robin arbiter with valid/ready handshakes.
- The result is registered, with one response slot that supports back-pressure.
- Sits between user-facing command sources and the combinational shifter inside a user module; the top-level wrapper maps the pins onto these ports.

Parameters:
- WIDTH, 4, operand/result width in bits; must be a power of two, at least 2.
- AMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- r0_valid  input  1  requester 0 command valid.
- r0_ready  output  1  requester 0 command accepted this cycle when r0_valid is also high.
- r0_data  input  WIDTH  requester 0 operand.
- r0_amt  input  AMT_W  requester 0 right-shift amount.
- r0_rot  input  1  requester 0 mode: 1 = rotate, 0 = fill.
- r0_fill  input  1  requester 0 fill bit, used when r0_rot=0.
- r1_valid, r1_ready, r1_data, r1_amt, r1_rot, r1_fill: same as requester 0, for requester 1.
- rsp_valid  output  1  result slot occupied.
- rsp_ready  input  1  consumer takes the result.
- rsp_data  output  WIDTH  shifted result.
- rsp_id  output  1  requester that issued the result.

Behaviour:
- Datapath function: out[i] = in[i+amt] when i+amt < WIDTH. Otherwise out[i] = rot ? in[i+amt-WIDTH] : fill. amt=0 is pass-through.
- Response-slot FSM has two states, EMPTY and FULL. Reset state is EMPTY.
- can_accept = (state==EMPTY) || (rsp_valid && rsp_ready).
- Grant rule:
  - Only r0_valid: grant 0.
  - Only r1_valid: grant 1.
  - Both valid: grant the requester other than last_gnt.
- rX_ready = can_accept && (grant==X). Readiness never depends combinationally on rsp_data.
- Accept (rX_valid && rX_ready): on the next edge, rsp_data/rsp_id load the shifted result and requester id, state goes to FULL, and last_gnt is set to X.
- Latency: exactly 1 cycle from accept to rsp_valid. Throughput is 1 result per cycle while rsp_ready=1.
- Drain with no accept: FULL goes to EMPTY.
- Drain and accept in the same cycle: state stays FULL and the new result is loaded.
- FULL && !rsp_ready:
  - both readies are 0;
  - rsp_data and rsp_id are held stable;
  - last_gnt does not change.
- Requesters must hold their command stable while valid && !ready. A requester may drop valid before it is granted; no grant is lost.
- last_gnt changes only on accept, so a requester with no competing request can be granted back-to-back.
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, last_gnt=1 (requester 0 wins the first tie).
- Asserting reset mid-operation discards any held result immediately (asynchronously).

Optional Feature:
- Macro: SHIFT_ARB_STATS_EN.
- Defined:
  - Adds output ports gnt_cnt0[7:0] and gnt_cnt1[7:0].
  - Each counter increments on every accept for its requester and saturates at 8'hFF.
  - Both reset to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package shift_arb_pkg holds:
  - localparam WIDTH_DEF=4;
  - typedef slot_state_t enum {EMPTY, FULL};
  - typedef req_id_t logic [0:0];
  - the saturation constant CNT_MAX=8'hFF.
- One sub-module, shift_core: purely combinational, parameterized by WIDTH, with ports in, amt, rot, fill, out. It is instantiated once after the grant mux.
- The arbiter, FSM and counters stay in the top module.

Test Plan:
- Reset, then r0_valid=1 with data=4'b1011, amt=1, rot=0, fill=0 -> r0_ready=1; next cycle rsp_valid=1, rsp_data=4'b0101, rsp_id=0.
- Same operand with rot=1 -> rsp_data=4'b1101. With data=4'b0000, amt=3, rot=0, fill=1 -> rsp_data=4'b1110. With amt=0 -> rsp_data equals data.
- Both requesters valid continuously, rsp_ready=1 for 6 cycles -> rsp_id sequence 0,1,0,1,0,1 with one result per cycle.
- Result held with rsp_ready=0 for 3 cycles and both requesters valid -> both readies 0 and rsp_data/rsp_id stable. Raise rsp_ready -> same-cycle drain and accept; next result comes from the requester not last granted.
- Pull rst_n low while rsp_valid=1 -> rsp_valid=0 and rsp_data=0 immediately. After release, a tie is granted to requester 0.
- With SHIFT_ARB_STATS_EN: 300 back-to-back requester-0 accepts -> gnt_cnt0=8'hFF (saturated), gnt_cnt1=0.

Source files
------------

// File: rtl/shift_arb_pkg.sv
// shift_arb_pkg: shared types and constants for the shift unit arbiter
package shift_arb_pkg;
  localparam int WIDTH_DEF = 4;
  typedef enum logic {EMPTY, FULL} slot_state_t;
  typedef logic [0:0] req_id_t;
  localparam logic [7:0] CNT_MAX = 8'hFF;
endpackage

// File: rtl/shift_unit_arbiter_if.sv
// shift_unit_arbiter_if: two requester command channels plus the response slot
interface shift_unit_arbiter_if #(parameter int WIDTH = 4);
  localparam int AMT_W = $clog2(WIDTH);
  logic r0_valid, r0_ready, r0_rot, r0_fill;
  logic [WIDTH-1:0] r0_data;
  logic [AMT_W-1:0] r0_amt;
  logic r1_valid, r1_ready, r1_rot, r1_fill;
  logic [WIDTH-1:0] r1_data;
  logic [AMT_W-1:0] r1_amt;
  logic rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0] rsp_data;
  modport master(
    output r0_valid, r0_data, r0_amt, r0_rot, r0_fill, input r0_ready,
    output r1_valid, r1_data, r1_amt, r1_rot, r1_fill, input r1_ready,
    input rsp_valid, rsp_data, rsp_id, output rsp_ready
  );
  modport slave(
    input r0_valid, r0_data, r0_amt, r0_rot, r0_fill, output r0_ready,
    input r1_valid, r1_data, r1_amt, r1_rot, r1_fill, output r1_ready,
    output rsp_valid, rsp_data, rsp_id, input rsp_ready
  );
endinterface

// File: rtl/shift_core.sv
// shift_core: combinational right shift with rotate or constant fill
module shift_core #(
  parameter int WIDTH = 4,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in,
  input  logic [AMT_W-1:0] amt,
  input  logic             rot,
  input  logic             fill,
  output logic [WIDTH-1:0] out
);
  logic [2*WIDTH-1:0] ext;
  // upper half supplies bits shifted in from the top: the operand again for rotate
  assign ext = {rot ? in : {WIDTH{fill}}, in} >> amt;
  assign out = ext[WIDTH-1:0];
endmodule

// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: round-robin share of one shifter with a registered response slot
// Define SHIFT_ARB_STATS_EN to add saturating per-requester grant counters.
module shift_unit_arbiter
  import shift_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  shift_unit_arbiter_if.slave bus
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [7:0] gnt_cnt0,
  output logic [7:0] gnt_cnt1
`endif
);
  slot_state_t state;
  req_id_t last_gnt, gnt, rsp_id;
  logic can_accept, accept;
  logic [WIDTH-1:0] sh_out, rsp_data;
  assign can_accept = state == EMPTY || bus.rsp_ready;
  assign gnt = (bus.r0_valid && bus.r1_valid) ? ~last_gnt : req_id_t'(bus.r1_valid);
  assign bus.r0_ready = can_accept && gnt == 1'b0;
  assign bus.r1_ready = can_accept && gnt == 1'b1;
  assign accept = can_accept && (gnt[0] ? bus.r1_valid : bus.r0_valid);
  assign bus.rsp_valid = state == FULL;
  assign bus.rsp_data = rsp_data;
  assign bus.rsp_id = rsp_id[0];
  shift_core #(.WIDTH(WIDTH)) u_core (
    .in  (gnt[0] ? bus.r1_data : bus.r0_data),
    .amt (gnt[0] ? bus.r1_amt  : bus.r0_amt),
    .rot (gnt[0] ? bus.r1_rot  : bus.r0_rot),
    .fill(gnt[0] ? bus.r1_fill : bus.r0_fill),
    .out (sh_out)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= EMPTY;
      rsp_data <= '0;
      rsp_id   <= '0;
      last_gnt <= 1'b1;
    end else if (accept) begin
      state    <= FULL;
      rsp_data <= sh_out;
      rsp_id   <= gnt;
      last_gnt <= gnt;
    end else if (bus.rsp_ready) begin
      state <= EMPTY;
    end
`ifdef SHIFT_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (accept) begin
      if (gnt == 1'b0 && gnt_cnt0 != CNT_MAX) gnt_cnt0 <= gnt_cnt0 + 8'd1;
      if (gnt == 1'b1 && gnt_cnt1 != CNT_MAX) gnt_cnt1 <= gnt_cnt1 + 8'd1;
    end
`endif
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb_shift_unit_arbiter: directed scoreboard bench for shift_unit_arbiter
module tb_shift_unit_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int fails = 0;
  bit tb_last = 1'b1;
  logic [4:0] sb[$];
  always #5 clk = ~clk;
  shift_unit_arbiter_if #(.WIDTH(4)) bus ();
`ifdef SHIFT_ARB_STATS_EN
  logic [7:0] gnt_cnt0, gnt_cnt1;
  shift_unit_arbiter #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1));
`else
  shift_unit_arbiter #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  function automatic logic [3:0] model(input logic [3:0] d, input logic [1:0] a, input bit rot, input bit fill);
    logic [3:0] o;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = i + int'(a);
      o[i] = (k < 4) ? d[k] : (rot ? d[k-4] : fill);
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit v0, input logic [3:0] d0, input logic [1:0] a0, input bit o0, input bit f0,
                     input bit v1, input logic [3:0] d1, input logic [1:0] a1, input bit o1, input bit f1,
                     input bit rr);
    bit can, g, drain;
    @(negedge clk);
    bus.r0_valid = v0; bus.r0_data = d0; bus.r0_amt = a0; bus.r0_rot = o0; bus.r0_fill = f0;
    bus.r1_valid = v1; bus.r1_data = d1; bus.r1_amt = a1; bus.r1_rot = o1; bus.r1_fill = f1;
    bus.rsp_ready = rr;
    #1;
    can = sb.size() == 0 || rr;
    g = (v0 && v1) ? ~tb_last : v1;
    chk("r0_ready", {7'd0, bus.r0_ready}, {7'd0, can && !g});
    chk("r1_ready", {7'd0, bus.r1_ready}, {7'd0, can && g});
    drain = sb.size() != 0 && rr;
    @(posedge clk);
    #1;
    if (drain) void'(sb.pop_front());
    if (can && (g ? v1 : v0)) begin
      sb.push_back(g ? {1'b1, model(d1, a1, o1, f1)} : {1'b0, model(d0, a0, o0, f0)});
      tb_last = g;
    end
    chk("rsp_valid", {7'd0, bus.rsp_valid}, {7'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      chk("rsp_data", {4'd0, bus.rsp_data}, {4'd0, sb[0][3:0]});
      chk("rsp_id", {7'd0, bus.rsp_id}, {7'd0, sb[0][4]});
    end
  endtask

  initial begin
    bus.r0_valid = 0; bus.r0_data = 0; bus.r0_amt = 0; bus.r0_rot = 0; bus.r0_fill = 0;
    bus.r1_valid = 0; bus.r1_data = 0; bus.r1_amt = 0; bus.r1_rot = 0; bus.r1_fill = 0;
    bus.rsp_ready = 0;
    repeat (2) @(negedge clk);
    chk("reset_valid", {7'd0, bus.rsp_valid}, 8'd0);
    chk("reset_data", {4'd0, bus.rsp_data}, 8'd0);
    chk("reset_id", {7'd0, bus.rsp_id}, 8'd0);
    rst_n = 1'b1;
    cyc(1, 4'b1011, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("fill_shift", {4'd0, bus.rsp_data}, 8'b0101);
    cyc(1, 4'b1011, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    chk("rotate", {4'd0, bus.rsp_data}, 8'b1101);
    cyc(1, 4'b0000, 3, 0, 1, 0, 0, 0, 0, 0, 1);
    chk("fill_ones", {4'd0, bus.rsp_data}, 8'b1110);
    cyc(1, 4'b1010, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("amt_zero", {4'd0, bus.rsp_data}, 8'b1010);
    cyc(0, 0, 0, 0, 0, 1, 4'b0110, 2, 1, 0, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 4'(i), 2'(i), 1'(i), 1'(i >> 1), 1, 4'(15 - i), 2'(i + 1), 1'(i >> 1), 1'(i), 1);
      chk("rr_id", {7'd0, bus.rsp_id}, {7'd0, 1'(i)});
    end
    for (int i = 0; i < 3; i++) cyc(1, 4'b1100, 1, 0, 1, 1, 4'b0011, 2, 1, 0, 0);
    cyc(1, 4'b1100, 1, 0, 1, 1, 4'b0011, 2, 1, 0, 1);
    chk("after_hold_id", {7'd0, bus.rsp_id}, 8'd0);
    cyc(1, 4'b1001, 3, 1, 0, 1, 4'b0101, 1, 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {7'd0, bus.rsp_valid}, 8'd0);
    chk("async_rst_data", {4'd0, bus.rsp_data}, 8'd0);
    sb.delete();
    tb_last = 1'b1;
    bus.r0_valid = 0; bus.r1_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 4'b0111, 1, 1, 0, 1, 4'b1000, 1, 0, 1, 1);
    chk("post_rst_tie", {7'd0, bus.rsp_id}, 8'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef SHIFT_ARB_STATS_EN
    for (int i = 0; i < 300; i++) cyc(1, 4'(i), 2'(i), 1'(i), 1'(i >> 2), 0, 0, 0, 0, 0, 1);
    chk("gnt_cnt0", gnt_cnt0, 8'hFF);
    chk("gnt_cnt1", gnt_cnt1, 8'h00);
`endif
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
